// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, buffer geometry, pixel field positions and colour expansion
package vga_pkg;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP = 33;
  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_SCREEN_WIDTH = 160;
  localparam int unsigned VGA_SCREEN_HEIGHT = 120;
  localparam int unsigned VGA_SCALE_SHIFT = 2;
  localparam int unsigned R_MSB = 5;
  localparam int unsigned G_MSB = 3;
  localparam int unsigned B_MSB = 1;
  function automatic logic [7:0] expand(input logic [1:0] c);
    return {4{c}};
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster counters (vga_clk, reset in; h_count, v_count, active0, hs0, vs0, frame_start, in_vblank out)
module vga_timing import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP = VGA_H_FP,
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP = VGA_V_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP = VGA_V_BP
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       active0,
  output logic       hs0,
  output logic       vs0,
  output logic       frame_start,
  output logic       in_vblank
);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] HS_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] VS_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic [9:0] h_q, h_d, v_q, v_d;
  always_comb begin
    h_d = h_q == H_LAST ? 10'd0 : h_q + 10'd1;
    v_d = h_q != H_LAST ? v_q : v_q == V_LAST ? 10'd0 : v_q + 10'd1;
  end
  always_ff @(posedge vga_clk) begin
    h_q <= reset ? 10'd0 : h_d;
    v_q <= reset ? 10'd0 : v_d;
  end
  assign h_count = h_q;
  assign v_count = v_q;
  assign active0 = h_q < HA && v_q < VA;
  assign hs0 = !(h_q >= HS_LO && h_q < HS_HI);
  assign vs0 = !(v_q >= VS_LO && v_q < VS_HI);
  assign frame_start = h_q == 10'd0 && v_q == 10'd0;
  assign in_vblank = v_q >= VA;
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster scanout (vga_clk, reset, vga_dado in; buffer read port, RGB/sync/blank pins, frame_start, in_vblank out)
module vga_scanout import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP = VGA_H_FP,
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP = VGA_V_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP = VGA_V_BP,
  parameter int unsigned SCREEN_WIDTH = VGA_SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT = VGA_SCREEN_HEIGHT,
  parameter int unsigned SCALE_SHIFT = VGA_SCALE_SHIFT
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic       vga_read,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  input  logic [5:0] vga_dado,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       frame_start,
  output logic       in_vblank
);
  localparam logic [9:0] SW = 10'(SCREEN_WIDTH);
  localparam logic [9:0] SH = 10'(SCREEN_HEIGHT);
  logic [9:0] h_count, v_count;
  logic active0, hs0, vs0;
  logic act1_q, inr1_q, hs1_q, vs1_q, hs2_q, vs2_q, bn2_q;
  logic [7:0] r2_q, g2_q, b2_q;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .vga_clk(vga_clk),
    .reset(reset),
    .h_count(h_count),
    .v_count(v_count),
    .active0(active0),
    .hs0(hs0),
    .vs0(vs0),
    .frame_start(frame_start),
    .in_vblank(in_vblank)
  );
  assign vga_x = h_count >> SCALE_SHIFT;
  assign vga_y = v_count >> SCALE_SHIFT;
  assign vga_read = active0 && vga_x < SW && vga_y < SH;
  // stage 1 waits out the buffer's read latency; stage 2 registers the pins
  always_ff @(posedge vga_clk) begin
    act1_q <= !reset && active0;
    inr1_q <= !reset && vga_read;
    hs1_q <= reset || hs0;
    vs1_q <= reset || vs0;
    hs2_q <= reset || hs1_q;
    vs2_q <= reset || vs1_q;
    bn2_q <= !reset && act1_q;
    r2_q <= reset || !inr1_q ? 8'd0 : expand(vga_dado[R_MSB -: 2]);
    g2_q <= reset || !inr1_q ? 8'd0 : expand(vga_dado[G_MSB -: 2]);
    b2_q <= reset || !inr1_q ? 8'd0 : expand(vga_dado[B_MSB -: 2]);
  end
  assign vga_hs = hs2_q;
  assign vga_vs = vs2_q;
  assign vga_blank_n = bn2_q;
  assign vga_r = r2_q;
  assign vga_g = g2_q;
  assign vga_b = b2_q;
  assign vga_sync_n = 1'b0;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks three scanout instances (default, small full-width, small out-of-range) against a raster model
module tb_vga_scanout;
  logic vga_clk = 1'b0;
  logic reset = 1'b1;
  always #20 vga_clk = ~vga_clk;

  logic rd0, rd1, rd2, hs0, hs1, hs2, vs0, vs1, vs2, bn0, bn1, bn2, sn0, sn1, sn2, fs0, fs1, fs2, vb0, vb1, vb2;
  logic [9:0] x0, x1, x2, y0, y1, y2;
  logic [7:0] r0, r1, r2, g0, g1, g2, b0, b1, b2;
  logic [5:0] dado0, dado1, dado2;

  vga_scanout u_def (
    .vga_clk(vga_clk), .reset(reset), .vga_read(rd0), .vga_x(x0), .vga_y(y0), .vga_dado(dado0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0), .vga_blank_n(bn0),
    .vga_sync_n(sn0), .frame_start(fs0), .in_vblank(vb0)
  );
  vga_scanout #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .SCREEN_WIDTH(16), .SCREEN_HEIGHT(10), .SCALE_SHIFT(2)
  ) u_small (
    .vga_clk(vga_clk), .reset(reset), .vga_read(rd1), .vga_x(x1), .vga_y(y1), .vga_dado(dado1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1), .vga_blank_n(bn1),
    .vga_sync_n(sn1), .frame_start(fs1), .in_vblank(vb1)
  );
  vga_scanout #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .SCREEN_WIDTH(10), .SCREEN_HEIGHT(10), .SCALE_SHIFT(2)
  ) u_oor (
    .vga_clk(vga_clk), .reset(reset), .vga_read(rd2), .vga_x(x2), .vga_y(y2), .vga_dado(dado2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hs(hs2), .vga_vs(vs2), .vga_blank_n(bn2),
    .vga_sync_n(sn2), .frame_start(fs2), .in_vblank(vb2)
  );

  int ncmp = 0, nfail = 0, k = 0, cyc = 0;
  int mode = 1;
  logic [5:0] mem [0:119][0:159];
  bit track = 0;
  logic hs_prev = 1'b1;
  int fall1 = -1, fall2 = -1, low_len = 0, fs_a = -1, fs_b = -1, vs_low = 0, vb_cnt = 0;

  function automatic logic [5:0] pix(input int x, input int y);
    logic [5:0] d;
    d = 6'b111001;
    if (mode == 0) d = mem[y % 120][x % 160];
    if (mode == 1) d = {x[2:0], y[2:0]};
    return d;
  endfunction

  always @(posedge vga_clk) begin
    if (rd0) dado0 <= pix(int'(x0), int'(y0));
    if (rd1) dado1 <= pix(int'(x1), int'(y1));
    if (rd2) dado2 <= pix(int'(x2), int'(y2));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      if (nfail <= 30) $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic check_inst(input string n, input int ha, hf, hsw, hb, va, vf, vsw, vb, sw, sh,
                            input logic rd, input logic [9:0] x, y, input logic [7:0] r, g, b,
                            input logic hs, vs, bn, sn, fs, ivb);
    int ht, vt, ft, h, v, ph, pv;
    logic erd, ehs, evs, ebn;
    logic [5:0] d;
    logic [7:0] er, eg, eb;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ft = ht * vt;
    h = (k % ft) % ht;
    v = (k % ft) / ht;
    erd = h < ha && v < va && h / 4 < sw && v / 4 < sh;
    chk({n, ".read"}, 32'(rd), 32'(erd));
    if (erd) begin
      chk({n, ".x"}, 32'(x), 32'(h / 4));
      chk({n, ".y"}, 32'(y), 32'(v / 4));
    end
    chk({n, ".frame_start"}, 32'(fs), 32'(k % ft == 0));
    chk({n, ".in_vblank"}, 32'(ivb), 32'(v >= va));
    chk({n, ".sync_n"}, 32'(sn), 32'd0);
    ehs = 1'b1; evs = 1'b1; ebn = 1'b0; er = 8'd0; eg = 8'd0; eb = 8'd0;
    if (k >= 2) begin
      ph = ((k - 2) % ft) % ht;
      pv = ((k - 2) % ft) / ht;
      ehs = !(ph >= ha + hf && ph < ha + hf + hsw);
      evs = !(pv >= va + vf && pv < va + vf + vsw);
      ebn = ph < ha && pv < va;
      if (ebn && ph / 4 < sw && pv / 4 < sh) begin
        d = pix(ph / 4, pv / 4);
        er = 8'(int'(d[5:4]) * 85);
        eg = 8'(int'(d[3:2]) * 85);
        eb = 8'(int'(d[1:0]) * 85);
      end
    end
    chk({n, ".hs"}, 32'(hs), 32'(ehs));
    chk({n, ".vs"}, 32'(vs), 32'(evs));
    chk({n, ".blank_n"}, 32'(bn), 32'(ebn));
    chk({n, ".r"}, 32'(r), 32'(er));
    chk({n, ".g"}, 32'(g), 32'(eg));
    chk({n, ".b"}, 32'(b), 32'(eb));
  endtask

  task automatic step();
    @(posedge vga_clk);
    k = reset ? 0 : k + 1;
    cyc++;
    @(negedge vga_clk);
    check_inst("def", 640, 16, 96, 48, 480, 10, 2, 33, 160, 120,
               rd0, x0, y0, r0, g0, b0, hs0, vs0, bn0, sn0, fs0, vb0);
    check_inst("small", 64, 4, 8, 4, 40, 2, 2, 4, 16, 10,
               rd1, x1, y1, r1, g1, b1, hs1, vs1, bn1, sn1, fs1, vb1);
    check_inst("oor", 64, 4, 8, 4, 40, 2, 2, 4, 10, 10,
               rd2, x2, y2, r2, g2, b2, hs2, vs2, bn2, sn2, fs2, vb2);
    if (track) begin
      if (hs_prev && !hs0) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      if (!hs0 && fall1 >= 0 && fall2 < 0) low_len++;
      hs_prev = hs0;
      if (fs1) begin
        if (fs_a < 0) fs_a = cyc;
        else if (fs_b < 0) fs_b = cyc;
      end
      if (!vs1) vs_low++;
      if (vb1) vb_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 120; i++)
      for (int j = 0; j < 160; j++) mem[i][j] = 6'($urandom);
    dado0 = '0; dado1 = '0; dado2 = '0;
    mode = 1;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    track = 1;
    repeat (7690) step();
    track = 0;
    chk("def.hs_first_fall", 32'(fall1), 32'd658);
    chk("def.hs_low_len", 32'(low_len), 32'd96);
    chk("def.hs_period", 32'(fall2 - fall1), 32'd800);
    chk("small.frame_period", 32'(fs_b - fs_a), 32'd3840);
    chk("small.vs_low_cycles", 32'(vs_low), 32'd320);
    chk("small.vblank_cycles", 32'(vb_cnt), 32'd1280);

    reset = 1'b1;
    mode = 2;
    repeat (2) step();
    reset = 1'b0;
    repeat (4000) step();

    reset = 1'b1;
    mode = 0;
    for (int i = 0; i < 120; i++)
      for (int j = 0; j < 160; j++) mem[i][j] = 6'($urandom);
    repeat (2) step();
    reset = 1'b0;
    repeat (1630) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat ($urandom_range(2000, 500)) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
